// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int          INST_BYTES = 4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, inst} entries between fetch and decode.
// Flush has priority over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int QUEUE_DEPTH = 4,
  localparam int PTR_W       = $clog2(QUEUE_DEPTH),
  localparam int CNT_W       = PTR_W + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       push_entry,
  output fetch_entry_t       head,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(QUEUE_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: the storage array has no reset; count/pointers alone define which
  // entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC, drives the icache, queues {pc, inst} for decode.
// Optional zero-latency bypass of an empty queue: define FETCH_BYPASS_EN.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] cache_address,
  output logic        cache_read_enable,
  input  logic [31:0] cache_inst,
  input  logic        cache_waitrequest,
  input  logic        cache_inst_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      pending_pc;
  logic             hold;
  logic             pending;
  logic             accept;
  logic             stalled;
  logic             keep;
  logic             q_push;
  logic             q_pop;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_head;
  fetch_entry_t     new_entry;
  fetch_entry_t     out_entry;

  assign cache_address     = fetch_pc;
  assign cache_read_enable = !reset && (!q_full || hold);
  assign accept            = cache_read_enable && cache_inst_valid && !cache_waitrequest;
  // A refill still outstanding this cycle; a redirect now must be deferred.
  assign stalled           = hold && !accept;
  assign keep              = accept && !pending && !redirect_valid;
  assign new_entry         = '{pc: fetch_pc, inst: cache_inst};

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = keep && q_empty;
  assign out_valid = !q_empty || bypass;
  assign out_entry = q_empty ? new_entry : q_head;
  assign q_push    = keep && !(bypass && out_ready);
`else
  assign out_valid = !q_empty;
  assign out_entry = q_head;
  assign q_push    = keep;
`endif

  assign q_pop    = out_ready && !q_empty;
  assign out_pc   = out_valid ? out_entry.pc   : 32'h0;
  assign out_inst = out_valid ? out_entry.inst : NOP_INST;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc   <= align_pc(RESET_PC);
      pending_pc <= '0;
      hold       <= 1'b0;
      pending    <= 1'b0;
    end else if (redirect_valid && stalled) begin
      pending    <= 1'b1;
      pending_pc <= align_pc(redirect_pc);
    end else if (redirect_valid) begin
      fetch_pc <= align_pc(redirect_pc);
      hold     <= 1'b0;
      pending  <= 1'b0;
    end else if (accept) begin
      hold     <= 1'b0;
      pending  <= 1'b0;
      fetch_pc <= pending ? pending_pc : fetch_pc + INST_BYTES;
    end else if (cache_read_enable && cache_waitrequest) begin
      hold <= 1'b1;
    end
  end

  fetch_queue #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (q_push),
    .pop        (q_pop),
    .flush      (redirect_valid),
    .push_entry (new_entry),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit (RESET_PC = 0x100, depth 4).
module tb_inst_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] cache_address;
  logic        cache_read_enable;
  logic [31:0] cache_inst;
  logic        cache_waitrequest;
  logic        cache_inst_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] INST_KEY = 32'hA5A5_0000;

  always #5 clock = ~clock;

  // Cache returns a word derived from its address so data/pc pairing is visible.
  assign cache_inst = cache_address ^ INST_KEY;

  inst_fetch_unit #(.RESET_PC(32'h0000_0100), .QUEUE_DEPTH(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .cache_address     (cache_address),
    .cache_read_enable (cache_read_enable),
    .cache_inst        (cache_inst),
    .cache_waitrequest (cache_waitrequest),
    .cache_inst_valid  (cache_inst_valid),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .out_valid         (out_valid),
    .out_inst          (out_inst),
    .out_pc            (out_pc),
    .out_ready         (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset             = 1'b1;
    cache_waitrequest = 1'b0;
    cache_inst_valid  = 1'b1;
    redirect_valid    = 1'b0;
    redirect_pc       = 32'h0;
    out_ready         = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_rden", 32'(cache_read_enable), 32'h0);
    chk("rst_oval", 32'(out_valid), 32'h0);
    chk("rst_addr", cache_address, 32'h100);

    // Always-hit streaming after reset release.
    reset = 1'b0;
    #1;
    chk("run_rden", 32'(cache_read_enable), 32'h1);
    chk("run_addr0", cache_address, 32'h100);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("run_addr", cache_address, 32'h100 + 32'(4 * k));
      chk("run_oval", 32'(out_valid), 32'h1);
      chk("run_opc", out_pc, 32'h100 + 32'(4 * (k - 1)));
      chk("run_inst", out_inst, (32'h100 + 32'(4 * (k - 1))) ^ INST_KEY);
    end

    // Redirect to 0x140, then a 20-cycle miss there.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h140;
    step();
    redirect_valid = 1'b0;
    chk("redir_oval", 32'(out_valid), 32'h0);
    chk("redir_addr", cache_address, 32'h140);
    cache_waitrequest = 1'b1;
    cache_inst_valid  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("miss_addr", cache_address, 32'h140);
      chk("miss_rden", 32'(cache_read_enable), 32'h1);
    end
    out_ready         = 1'b0;
    cache_waitrequest = 1'b0;
    cache_inst_valid  = 1'b1;
    step();
    cache_inst_valid = 1'b0;
    chk("fill_addr", cache_address, 32'h144);
    chk("fill_oval", 32'(out_valid), 32'h1);
    chk("fill_opc", out_pc, 32'h140);
    chk("fill_inst", out_inst, 32'h140 ^ INST_KEY);
    step();
    chk("fill_once_addr", cache_address, 32'h144);
    out_ready = 1'b1;
    step();
    chk("fill_once_oval", 32'(out_valid), 32'h0);

    // Redirect to a misaligned target while a miss is stalled.
    redirect_valid   = 1'b1;
    redirect_pc      = 32'h138;
    cache_inst_valid = 1'b1;
    out_ready        = 1'b0;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    chk("pre_miss_addr", cache_address, 32'h140);
    cache_waitrequest = 1'b1;
    cache_inst_valid  = 1'b0;
    repeat (3) step();
    chk("pre_redir_opc", out_pc, 32'h138);
    chk("pre_redir_oval", 32'(out_valid), 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    step();
    redirect_valid = 1'b0;
    chk("hredir_oval", 32'(out_valid), 32'h0);
    chk("hredir_addr", cache_address, 32'h140);
    chk("hredir_rden", 32'(cache_read_enable), 32'h1);
    repeat (2) step();
    chk("hredir_hold", cache_address, 32'h140);
    cache_waitrequest = 1'b0;
    cache_inst_valid  = 1'b1;
    out_ready         = 1'b1;
    step();
    chk("discard_oval", 32'(out_valid), 32'h0);
    chk("discard_addr", cache_address, 32'h200);
    step();
    chk("target_oval", 32'(out_valid), 32'h1);
    chk("target_opc", out_pc, 32'h200);
    chk("target_addr", cache_address, 32'h204);

    // Fill to depth with decode stalled, then drain across pointer wrap.
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    step();
    redirect_valid = 1'b0;
    chk("full_start", cache_address, 32'h400);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("full_addr", cache_address, 32'h400 + 32'(4 * k));
      chk("full_rden", 32'(cache_read_enable), (k < 4) ? 32'h1 : 32'h0);
    end
    step();
    chk("full_stay_rden", 32'(cache_read_enable), 32'h0);
    chk("full_stay_addr", cache_address, 32'h410);
    chk("full_head", out_pc, 32'h400);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("drain_opc", out_pc, 32'h400 + 32'(4 * i));
      chk("drain_inst", out_inst, (32'h400 + 32'(4 * i)) ^ INST_KEY);
    end

    // Full queue: redirect and pop in the same cycle.
    out_ready = 1'b0;
    repeat (2) step();
    chk("refull_rden", 32'(cache_read_enable), 32'h0);
    chk("refull_head", out_pc, 32'h420);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    step();
    redirect_valid = 1'b0;
    chk("rpop_oval", 32'(out_valid), 32'h0);
    chk("rpop_addr", cache_address, 32'h500);
    step();
    chk("rpop_next_oval", 32'(out_valid), 32'h1);
    chk("rpop_next_opc", out_pc, 32'h500);

    // PC wraps modulo 2^32; misaligned bits cleared.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr0", cache_address, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr1", cache_address, 32'h0);
    chk("wrap_opc0", out_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_opc1", out_pc, 32'h0);

`ifdef FETCH_BYPASS_EN
    // Empty queue, hit at 0x300 with decode ready: same-cycle presentation.
    cache_inst_valid = 1'b0;
    redirect_valid   = 1'b1;
    redirect_pc      = 32'h300;
    step();
    redirect_valid = 1'b0;
    step();
    cache_inst_valid = 1'b1;
    #1;
    chk("byp_oval", 32'(out_valid), 32'h1);
    chk("byp_opc", out_pc, 32'h300);
    step();
    cache_inst_valid = 1'b0;
    #1;
    chk("byp_nopush", 32'(out_valid), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
